// File: rtl/condition_codes_pkg.sv
// Condition-code encodings and NZCV flag positions shared by the condition logic.
package condition_codes_pkg;

    localparam int FLAG_WIDTH = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } condition_code_t;

endpackage

// File: rtl/condition_check.sv
// Purely combinational evaluation of a 4-bit ARM condition field against stored NZCV flags.
module condition_check
    import condition_codes_pkg::*;
(
    input  logic [3:0]            condition,
    input  logic [FLAG_WIDTH-1:0] flags,
    output logic                  condition_met
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        condition_met = 1'b0;
        case (condition_code_t'(condition))
            EQ: condition_met = z;
            NE: condition_met = ~z;
            CS: condition_met = c;
            CC: condition_met = ~c;
            MI: condition_met = n;
            PL: condition_met = ~n;
            VS: condition_met = v;
            VC: condition_met = ~v;
            HI: condition_met = ~z & c;
            LS: condition_met = z | ~c;
            GE: condition_met = (n == v);
            LT: condition_met = (n != v);
            GT: condition_met = ~z & (n == v);
            LE: condition_met = z | (n != v);
            AL: condition_met = 1'b1;
            // NV never executes; listed so the result is a defined 0 rather than a default fall-through
            NV: condition_met = 1'b0;
            default: condition_met = 1'b0;
        endcase
    end

endmodule

// File: rtl/conditional_logic.sv
// NZCV flag storage and condition gating of decoder write/PC requests.
// Optional macro CONDITIONAL_LOGIC_STALL_EN adds a stall input that freezes flags and gated writes.
module conditional_logic
    import condition_codes_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
`ifdef CONDITIONAL_LOGIC_STALL_EN
    input  logic                  stall,
`endif
    input  logic [3:0]            condition,
    input  logic [FLAG_WIDTH-1:0] alu_flags,
    input  logic [1:0]            flag_write,
    input  logic                  potential_program_counter,
    input  logic                  register_write_enable,
    input  logic                  memory_write_enable,
    output logic                  program_counter_source,
    output logic                  register_write,
    output logic                  memory_write,
    output logic                  condition_met,
    output logic [FLAG_WIDTH-1:0] flags
);

    logic [FLAG_WIDTH-1:0] flags_q;
    logic [FLAG_WIDTH-1:0] flags_d;
    logic                  issue_ok;

    condition_check u_condition_check (
        .condition     (condition),
        .flags         (flags_q),
        .condition_met (condition_met)
    );

`ifdef CONDITIONAL_LOGIC_STALL_EN
    assign issue_ok = condition_met & ~stall;
`else
    assign issue_ok = condition_met;
`endif

    // ANDing with issue_ok first keeps unknown decoder requests from reaching the flags when squashed
    always_comb begin
        flags_d = flags_q;
        if (issue_ok & flag_write[1]) begin
            flags_d[FLAG_N] = alu_flags[FLAG_N];
            flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (issue_ok & flag_write[0]) begin
            flags_d[FLAG_C] = alu_flags[FLAG_C];
            flags_d[FLAG_V] = alu_flags[FLAG_V];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign program_counter_source = issue_ok & potential_program_counter;
    assign register_write         = issue_ok & register_write_enable;
    assign memory_write           = issue_ok & memory_write_enable;
    assign flags                  = flags_q;

endmodule
